fpu_result_log: RTL and testbench
=================================

Name: fpu_result_log

Overview:
- Capture-side counterpart of the FPU stimulus vector ROM: records FPU results, tagged with their 2-bit op code, into a 256-entry result memory for post-run comparison.
- Packed entry format {op[1:0], result[15:0]} is 18 bits, the same op-then-data ordering as the stimulus vectors.
- Sits after the FPU in the validation harness. Accepts results through a valid/ready handshake, counts them against a target, and offers a registered readback port.

Parameters:
- DEPTH, 256, number of result entries.
- AW, 8, address width; DEPTH = 2^AW.
- DW, 16, result data width.

Ports:
- clock  in  1  Sole clock, rising edge.
- reset_n  in  1  Asynchronous, active-low reset.
- start  in  1  Single-cycle pulse: arm a capture run.
- target_count  in  AW+1  Number of results to capture; sampled only on start.
- res_valid  in  1  FPU result valid.
- res_ready  out  1  Logger able to accept a result.
- res_op  in  2  Op code of the result.
- res_data  in  DW  FPU result.
- rd_en  in  1  Readback request.
- rd_addr  in  AW  Readback address.
- rd_data  out  DW+2  Readback entry {op, result}.
- rd_valid  out  1  rd_data valid; pulses the cycle after rd_en.
- count  out  AW+1  Results captured in the current run.
- busy  out  1  In CAPTURE.
- done  out  1  Run complete, held until the next start.
- overflow  out  1  Sticky: a result was presented while not capturing.

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces:
  - state = IDLE; wr_ptr, count, target = 0;
  - res_ready, busy, done, overflow, rd_valid = 0; rd_data = 0.
  - Memory array is not reset.
- FSM states: IDLE, CAPTURE, DONE. Outputs are registered unless noted.
  - res_ready = busy = (state == CAPTURE).
  - done = (state == DONE).
- start, in any state, takes priority over everything else that cycle:
  - target = min(target_count, DEPTH); wr_ptr = 0; count = 0; done = 0; overflow = 0.
  - If target_count == 0, next state is DONE. Otherwise next state is CAPTURE.
  - A res_valid in the same cycle as start is not accepted: res_ready is low or about to be cleared, and the beat is not written.
  - start during CAPTURE aborts the run and restarts. Entries already written stay in memory.
- CAPTURE accept: the beat is taken when res_valid && res_ready. Then:
  - mem[wr_ptr] = {res_op, res_data}; wr_ptr += 1; count += 1.
  - If count + 1 == target, next state is DONE, so res_ready is low from the following cycle.
  - Exactly target beats are accepted per run. Maximum throughput is 1 beat per clock.
  - With target == DEPTH, wr_ptr wraps to 0 on the last write. This is harmless because the state leaves CAPTURE.
- IDLE or DONE with res_valid high and start low: overflow is set to 1 (sticky). Nothing is written and count is unchanged.
- Readback is legal in any state:
  - rd_en samples rd_addr; rd_data = mem[rd_addr] on the next edge; rd_valid = 1 for that one cycle.
  - Without rd_en, rd_data holds its value and rd_valid = 0.
  - Read and write to the same address in the same cycle returns the old contents (read-before-write).
- Reset mid-run: state returns to IDLE immediately. Memory contents are retained but undefined for the verifier.
- count saturates at target and never exceeds DEPTH.

Test Plan:
- Reset, then start with target_count=3. Send 3 back-to-back beats: (op=1, 0x3C00), (2, 0x4000), (3, 0xC200).
  - count goes 1, 2, 3. res_ready drops the cycle after the 3rd beat. done=1, busy=0, overflow=0.
  - Readback of addresses 0..2 gives 0x13C00, 0x24000, 0x3C200, each rd_valid one cycle after its rd_en.
- target_count=4 with res_valid toggling every other cycle: exactly 4 beats accepted, and wr_ptr advances only on handshake cycles.
- target_count=0: DONE on the next cycle, res_ready never asserted, count=0.
- target_count=300: clamped to 256. 256 beats accepted and a 257th held valid is refused. overflow=1 once in DONE. mem[255] holds the 256th beat.
- Restart and reset:
  - start asserted after 2 of 5 beats: count returns to 0 and the concurrent beat is dropped. The next accepted beat lands at address 0.
  - reset_n low mid-run: all outputs are 0 asynchronously, before the next clock edge.
- Readback collision: in CAPTURE, rd_en with rd_addr equal to the current wr_ptr during an accept. rd_data shows the old entry; reading the same address next cycle shows the new entry.

Source files
------------

// File: rtl/fpu_result_log.sv
// Logs FPU results as {op, result} into a DEPTH-entry memory for post-run comparison.
// Accepts up to 1 beat/clk while capturing; readback is registered with 1-cycle latency.
module fpu_result_log #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW:0]   target_count,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [1:0]    res_op,
  input  logic [DW-1:0] res_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW+1:0] rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          overflow
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_CAPT  = 2'd1;
  localparam logic [1:0]  S_DONE  = 2'd2;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   target_q, target_d;
  logic          overflow_q, overflow_d;
  logic [DW+1:0] rd_data_q;
  logic          rd_valid_q;
  logic [AW:0]   count_inc;
  logic          accept;

  logic [DW+1:0] mem [DEPTH];

  // start outranks a concurrent beat, so that beat is never written
  assign accept    = res_valid && (state_q == S_CAPT) && !start;
  assign count_inc = count_q + (AW + 1)'(1);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    target_d   = target_q;
    overflow_d = overflow_q;
    if (start) begin
      target_d   = (target_count > DEPTH_C) ? DEPTH_C : target_count;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      state_d    = (target_count == '0) ? S_DONE : S_CAPT;
    end else if (state_q == S_CAPT) begin
      if (res_valid) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_inc;
        if (count_inc == target_q) begin
          state_d = S_DONE;
        end
      end
    end else if (res_valid) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      target_q   <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      target_q   <= target_d;
      overflow_q <= overflow_d;
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= mem[rd_addr];
      end
    end
  end

  // Storage carries no reset; a same-address read sees the pre-write value
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[wr_ptr_q] <= {res_op, res_data};
    end
  end

  assign res_ready = (state_q == S_CAPT);
  assign busy      = (state_q == S_CAPT);
  assign done      = (state_q == S_DONE);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_fpu_result_log.sv
// Bench for fpu_result_log: table of capture runs, directed corner sequences, random traffic vs a model.
module tb_fpu_result_log;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [8:0]  target_count;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_op;
  logic [15:0] res_data;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [17:0] rd_data;
  logic        rd_valid;
  logic [8:0]  count;
  logic        busy;
  logic        done;
  logic        overflow;

  fpu_result_log dut (
    .clock(clock), .reset_n(reset_n), .start(start), .target_count(target_count),
    .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op), .res_data(res_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .busy(busy), .done(done), .overflow(overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a run captures while fewer than target beats have landed;
  // beat k of a run goes to address k mod 256.
  bit          m_started;
  int          m_target;
  int          m_count;
  bit          m_ovf;
  logic [17:0] m_mem [256];
  bit          m_known [256];
  logic [17:0] m_rd_data;
  bit          m_rd_known;
  bit          m_rd_valid;

  function automatic bit m_cap();
    return m_started && (m_count < m_target);
  endfunction

  function automatic bit m_done();
    return m_started && (m_count >= m_target);
  endfunction

  task automatic model_reset();
    m_started  = 1'b0;
    m_target   = 0;
    m_count    = 0;
    m_ovf      = 1'b0;
    m_rd_data  = '0;
    m_rd_known = 1'b1;
    m_rd_valid = 1'b0;
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
  endtask

  task automatic model_edge();
    if (rd_en) begin
      m_rd_valid = 1'b1;
      m_rd_data  = m_mem[rd_addr];
      m_rd_known = m_known[rd_addr];
    end else begin
      m_rd_valid = 1'b0;
    end
    if (start) begin
      m_started = 1'b1;
      m_target  = (int'(target_count) > 256) ? 256 : int'(target_count);
      m_count   = 0;
      m_ovf     = 1'b0;
    end else if (res_valid) begin
      if (m_cap()) begin
        m_mem[m_count % 256]   = {res_op, res_data};
        m_known[m_count % 256] = 1'b1;
        m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("res_ready", 32'(res_ready), 32'(m_cap()));
    chk("busy", 32'(busy), 32'(m_cap()));
    chk("done", 32'(done), 32'(m_done()));
    chk("count", 32'(count), 32'(m_count));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd_data));
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    res_valid = 1'b0;
    rd_en     = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res_ready"}, 32'(res_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
  endtask

  // Called just after a rising edge; checks outputs clear before any further edge.
  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    #1;
    chk_zero("async_rst");
    model_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic do_start(input int tc);
    start        = 1'b1;
    target_count = 9'(tc);
    cyc();
    start = 1'b0;
  endtask

  task automatic beat(input logic [1:0] op, input logic [15:0] d);
    res_valid = 1'b1;
    res_op    = op;
    res_data  = d;
    cyc();
    res_valid = 1'b0;
  endtask

  task automatic read(input int a);
    rd_en   = 1'b1;
    rd_addr = 8'(a);
    cyc();
    rd_en = 1'b0;
  endtask

  typedef struct {
    int tc;
    int offers;
    int exp_count;
    bit exp_done;
    bit exp_ovf;
  } run_vec_t;

  run_vec_t    tbl [7];
  logic [17:0] beats [300];
  logic [17:0] old_val;

  initial begin
    tbl[0] = '{tc: 3,   offers: 3,   exp_count: 3,   exp_done: 1'b1, exp_ovf: 1'b0};
    tbl[1] = '{tc: 1,   offers: 3,   exp_count: 1,   exp_done: 1'b1, exp_ovf: 1'b1};
    tbl[2] = '{tc: 0,   offers: 1,   exp_count: 0,   exp_done: 1'b1, exp_ovf: 1'b1};
    tbl[3] = '{tc: 300, offers: 257, exp_count: 256, exp_done: 1'b1, exp_ovf: 1'b1};
    tbl[4] = '{tc: 256, offers: 256, exp_count: 256, exp_done: 1'b1, exp_ovf: 1'b0};
    tbl[5] = '{tc: 5,   offers: 2,   exp_count: 2,   exp_done: 1'b0, exp_ovf: 1'b0};
    tbl[6] = '{tc: 8,   offers: 0,   exp_count: 0,   exp_done: 1'b0, exp_ovf: 1'b0};

    reset_n      = 1'b0;
    target_count = '0;
    res_op       = '0;
    res_data     = '0;
    rd_addr      = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;

    // Basic run with known values and readback
    do_start(3);
    beat(2'd1, 16'h3C00);
    chk("seq1_count1", 32'(count), 32'd1);
    beat(2'd2, 16'h4000);
    chk("seq1_count2", 32'(count), 32'd2);
    beat(2'd3, 16'hC200);
    chk("seq1_count3", 32'(count), 32'd3);
    chk("seq1_ready_low", 32'(res_ready), 32'd0);
    chk("seq1_done", 32'(done), 32'd1);
    chk("seq1_busy", 32'(busy), 32'd0);
    chk("seq1_ovf", 32'(overflow), 32'd0);
    read(0);
    chk("seq1_rd0", 32'(rd_data), 32'h13C00);
    read(1);
    chk("seq1_rd1", 32'(rd_data), 32'h24000);
    read(2);
    chk("seq1_rd2", 32'(rd_data), 32'h3C200);
    cyc();
    chk("seq1_rdv_drop", 32'(rd_valid), 32'd0);

    // Read/write collision at the current write pointer (address 2)
    do_start(4);
    beat(2'd0, 16'h1111);
    beat(2'd0, 16'h2222);
    rd_en   = 1'b1;
    rd_addr = 8'd2;
    beat(2'd0, 16'h1234);
    chk("coll_old", 32'(rd_data), 32'h3C200);
    cyc();
    rd_en = 1'b0;
    chk("coll_new", 32'(rd_data), 32'h01234);

    // Valid toggling every other cycle
    do_start(4);
    for (int i = 0; i < 8; i++) begin
      res_valid = (i % 2) == 1;
      res_op    = 2'(i);
      res_data  = 16'(16'hA000 + i);
      cyc();
    end
    res_valid = 1'b0;
    chk("tog_count", 32'(count), 32'd4);
    chk("tog_done", 32'(done), 32'd1);
    chk("tog_ovf", 32'(overflow), 32'd0);
    for (int a = 0; a < 4; a++) begin
      read(a);
      chk("tog_rd", 32'(rd_data), 32'({2'(2 * a + 1), 16'(16'hA000 + 2 * a + 1)}));
    end

    // Table of capture runs
    for (int t = 0; t < 7; t++) begin
      do_start(tbl[t].tc);
      for (int k = 0; k < tbl[t].offers; k++) begin
        beats[k] = 18'($urandom);
        beat(beats[k][17:16], beats[k][15:0]);
      end
      cyc();
      chk("tbl_count", 32'(count), 32'(tbl[t].exp_count));
      chk("tbl_done", 32'(done), 32'(tbl[t].exp_done));
      chk("tbl_ovf", 32'(overflow), 32'(tbl[t].exp_ovf));
      if (tbl[t].exp_count > 0) begin
        read(tbl[t].exp_count - 1);
        chk("tbl_last", 32'(rd_data), 32'(beats[tbl[t].exp_count - 1]));
      end
    end

    // Restart after 2 of 5 beats, with a beat in the start cycle
    do_start(5);
    beat(2'd1, 16'h0001);
    beat(2'd1, 16'h0002);
    start        = 1'b1;
    target_count = 9'd5;
    beat(2'd2, 16'hDEAD);
    start = 1'b0;
    chk("rst_count0", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    beat(2'd3, 16'hBEEF);
    read(0);
    chk("rst_addr0", 32'(rd_data), 32'h3BEEF);

    // Async reset in the middle of a run
    read(0);
    beat(2'd1, 16'h5555);
    do_reset();
    cyc();

    // Random traffic against the model
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      do_start(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 20)));
      for (int c = 0; c < 30 + int'($urandom_range(0, 40)); c++) begin
        start        = ($urandom_range(0, 40) == 0);
        target_count = 9'($urandom_range(0, 20));
        res_valid    = $urandom_range(0, 1) == 1;
        res_op       = 2'($urandom);
        res_data     = 16'($urandom);
        rd_en        = $urandom_range(0, 2) == 0;
        rd_addr      = 8'($urandom_range(0, 31));
        cyc();
        if ($urandom_range(0, 150) == 0) do_reset();
      end
      idle_inputs();
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
